// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control unit.
//   - RV32 opcode constants for the supported instruction classes
//   - 4-bit ALU operation codes (base set plus the extended set)
//   - FSM state enum and trap-cause enum
package multicycle_control_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct7 pattern selecting SUB (R-type) and SRA (extended shifts)
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_TIMEOUT = 2'b10
  } trap_cause_t;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational opcode / funct decode for the multicycle control unit.
// Ports:
//   i_opcode, i_funct3, i_funct7 : instruction fields
//   i_zero                       : ALU zero flag (branch resolution)
//   o_legal                      : opcode belongs to a supported class
//   o_is_load/o_is_store/o_is_branch : instruction class
//   o_alu_src                    : 1 = immediate operand
//   o_branch_taken               : beq/bne condition satisfied
//   o_alu_ctl                    : ALU operation for the EXECUTE state
// Optional feature: define MC_EXT_ALU_EN to decode XOR/SLTU/SLL/SRL/SRA;
// otherwise those funct3 values fall back to ADD.
module mc_alu_decode
  import multicycle_control_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_zero,
  output logic       o_legal,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic       o_is_branch,
  output logic       o_alu_src,
  output logic       o_branch_taken,
  output logic [3:0] o_alu_ctl
);

  logic w_alt;
  assign w_alt = (i_funct7 == FUNCT7_ALT);

  // Shared R/I arithmetic decode; SUB only exists for R-type, since the
  // I-type funct7 bits are part of the immediate.
  function automatic logic [3:0] arith_ctl(input logic [2:0] f3,
                                           input logic       alt,
                                           input logic       is_r);
    logic [3:0] ctl;
    ctl = ALU_ADD;
    case (f3)
      3'b000:  ctl = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b111:  ctl = ALU_AND;
      3'b110:  ctl = ALU_OR;
      3'b010:  ctl = ALU_SLT;
`ifdef MC_EXT_ALU_EN
      3'b100:  ctl = ALU_XOR;
      3'b011:  ctl = ALU_SLTU;
      3'b001:  ctl = ALU_SLL;
      3'b101:  ctl = alt ? ALU_SRA : ALU_SRL;
`endif
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  always_comb begin
    o_legal        = 1'b0;
    o_is_load      = 1'b0;
    o_is_store     = 1'b0;
    o_is_branch    = 1'b0;
    o_alu_src      = 1'b0;
    o_branch_taken = 1'b0;
    o_alu_ctl      = ALU_ADD;
    case (i_opcode)
      OP_RTYPE: begin
        o_legal   = 1'b1;
        o_alu_ctl = arith_ctl(i_funct3, w_alt, 1'b1);
      end
      OP_ITYPE: begin
        o_legal   = 1'b1;
        o_alu_src = 1'b1;
        o_alu_ctl = arith_ctl(i_funct3, w_alt, 1'b0);
      end
      OP_LOAD: begin
        o_legal   = 1'b1;
        o_is_load = 1'b1;
        o_alu_src = 1'b1;
      end
      OP_STORE: begin
        o_legal    = 1'b1;
        o_is_store = 1'b1;
        o_alu_src  = 1'b1;
      end
      OP_BRANCH: begin
        o_legal        = 1'b1;
        o_is_branch    = 1'b1;
        o_alu_ctl      = ALU_SUB;
        o_branch_taken = ((i_funct3 == 3'b000) &&  i_zero) ||
                         ((i_funct3 == 3'b001) && !i_zero);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK),
// with a TRAP state for illegal opcodes and memory-wait timeouts.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   instr            : instruction register contents
//   mem_ready, zero  : memory completion, ALU zero flag
//   mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
//   mem_to_reg, alu_src, alu_ctl : combinational datapath controls
//   state            : current FSM state (registered)
//   trap, trap_cause : registered trap status
// Parameters: TIMEOUT_W (wait counter width), TIMEOUT_MAX (wait cycles
// before a timeout trap, must fit in TIMEOUT_W bits).
// Optional feature: MC_EXT_ALU_EN enables the extended ALU decode.
//
// Memory handshake: mem_req is raised in FETCH and MEM and held until a
// cycle with mem_ready=1 completes the request (controls for that cycle
// already reflect completion), or until the wait counter expires. The
// request is never withdrawn otherwise; mem_ready is ignored when mem_req=0.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [3:0]  alu_ctl,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  state_t                r_state;
  logic [TIMEOUT_W-1:0]  r_wait_cnt;
  logic                  r_trap;
  trap_cause_t           r_trap_cause;

  logic       w_legal;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_branch;
  logic       w_alu_src;
  logic       w_branch_taken;
  logic [3:0] w_alu_ctl;
  logic       w_timeout;
  logic       w_unused_instr_bits;

  // Register-number and immediate bits are irrelevant to control.
  assign w_unused_instr_bits = ^{instr[24:15], instr[11:7]};

  mc_alu_decode u_decode (
    .i_opcode       (instr[6:0]),
    .i_funct3       (instr[14:12]),
    .i_funct7       (instr[31:25]),
    .i_zero         (zero),
    .o_legal        (w_legal),
    .o_is_load      (w_is_load),
    .o_is_store     (w_is_store),
    .o_is_branch    (w_is_branch),
    .o_alu_src      (w_alu_src),
    .o_branch_taken (w_branch_taken),
    .o_alu_ctl      (w_alu_ctl)
  );

  // Completion in the same cycle beats the timeout.
  assign w_timeout = mem_req && !mem_ready &&
                     (r_wait_cnt == TIMEOUT_W'(TIMEOUT_MAX));

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_ctl    = ALU_ADD;
    case (r_state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ST_EXECUTE: begin
        alu_src  = w_alu_src;
        alu_ctl  = w_alu_ctl;
        pc_write = w_is_branch && w_branch_taken;
        pc_src   = w_is_branch && w_branch_taken;
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = w_is_store;
      end
      ST_WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = w_is_load;
      end
      default: ;
    endcase
  end

  // Wait counter defaults to clear; it only counts while a request is
  // stalled and no state change happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_wait_cnt   <= '0;
      r_trap       <= 1'b0;
      r_trap_cause <= TC_NONE;
    end else begin
      r_wait_cnt <= '0;
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) begin
            r_state <= ST_DECODE;
          end else if (w_timeout) begin
            r_state      <= ST_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= TC_TIMEOUT;
          end else begin
            r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
          end
        end
        ST_DECODE: begin
          if (w_legal) begin
            r_state <= ST_EXECUTE;
          end else begin
            r_state      <= ST_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= TC_ILLEGAL;
          end
        end
        ST_EXECUTE: begin
          if (w_is_load || w_is_store) r_state <= ST_MEM;
          else if (w_is_branch)        r_state <= ST_FETCH;
          else                         r_state <= ST_WRITEBACK;
        end
        ST_MEM: begin
          if (mem_ready) begin
            r_state <= w_is_store ? ST_FETCH : ST_WRITEBACK;
          end else if (w_timeout) begin
            r_state      <= ST_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= TC_TIMEOUT;
          end else begin
            r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
          end
        end
        ST_WRITEBACK: r_state <= ST_FETCH;
        ST_TRAP:      r_state <= ST_TRAP;
        default:      r_state <= ST_FETCH;
      endcase
    end
  end

  assign state      = r_state;
  assign trap       = r_trap;
  assign trap_cause = r_trap_cause;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (TIMEOUT_MAX=4 instance).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic        reg_write, mem_to_reg, alu_src;
  logic [3:0]  alu_ctl;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe bus order: mem_req mem_we iord ir_write pc_write pc_src
  //                   reg_write mem_to_reg alu_src
  logic [8:0] strobes;
  assign strobes = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                    reg_write, mem_to_reg, alu_src};

  localparam logic [8:0] SB_NONE   = 9'b000000000;
  localparam logic [8:0] SB_FWAIT  = 9'b100000000;
  localparam logic [8:0] SB_FDONE  = 9'b100110000;
  localparam logic [8:0] SB_IMM    = 9'b000000001;
  localparam logic [8:0] SB_BR     = 9'b000011000;
  localparam logic [8:0] SB_MEM_LD = 9'b101000000;
  localparam logic [8:0] SB_MEM_ST = 9'b111000000;
  localparam logic [8:0] SB_WB_LD  = 9'b000000110;
  localparam logic [8:0] SB_WB     = 9'b000000100;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2,
                         S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110, A_SLT = 4'b0111;
`ifdef MC_EXT_ALU_EN
  localparam logic [3:0] A_XOR_EXP = 4'b0011;
`else
  localparam logic [3:0] A_XOR_EXP = 4'b0010;
`endif

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h0000A183;
  localparam logic [31:0] I_ILL = 32'h0000007F;

  multicycle_control #(.TIMEOUT_W(8), .TIMEOUT_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_ctl    (alu_ctl),
    .state      (state),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, drive all inputs, settle.
  task automatic step(input logic r, input logic [31:0] ins,
                      input logic rdy, input logic z);
    @(negedge clk);
    rst = r; instr = ins; mem_ready = rdy; zero = z;
    #1;
  endtask

  task automatic exp_cyc(input string tag, input logic [2:0] st,
                         input logic [8:0] sb, input logic [3:0] alu);
    check({tag, ".state"},   32'(state),   32'(st));
    check({tag, ".strobes"}, 32'(strobes), 32'(sb));
    check({tag, ".alu"},     32'(alu_ctl), 32'(alu));
  endtask

  task automatic check_trap(input string tag, input logic t, input logic [1:0] c);
    check({tag, ".trap"},  32'(trap),       32'(t));
    check({tag, ".cause"}, 32'(trap_cause), 32'(c));
  endtask

  task automatic run_alu(input string tag, input logic [31:0] ins,
                         input logic [3:0] alu, input logic asrc);
    step(0, ins, 1, 0); exp_cyc({tag, ".f"}, S_F, SB_FDONE, A_ADD);
    step(0, ins, 1, 0); exp_cyc({tag, ".d"}, S_D, SB_NONE, A_ADD);
    step(0, ins, 1, 0); exp_cyc({tag, ".e"}, S_E, {8'b0, asrc}, alu);
    step(0, ins, 1, 0); exp_cyc({tag, ".w"}, S_W, SB_WB, A_ADD);
  endtask

  task automatic run_branch(input string tag, input logic [31:0] ins,
                            input logic z, input logic taken);
    step(0, ins, 1, z); exp_cyc({tag, ".f"}, S_F, SB_FDONE, A_ADD);
    step(0, ins, 1, z); exp_cyc({tag, ".d"}, S_D, SB_NONE, A_ADD);
    step(0, ins, 1, z); exp_cyc({tag, ".e"}, S_E, taken ? SB_BR : SB_NONE, A_SUB);
  endtask

  task automatic run_mem(input string tag, input logic [31:0] ins, input logic st,
                         input int waits, input logic completes);
    logic [8:0] sb_mem;
    sb_mem = st ? SB_MEM_ST : SB_MEM_LD;
    step(0, ins, 1, 0); exp_cyc({tag, ".f"}, S_F, SB_FDONE, A_ADD);
    step(0, ins, 1, 0); exp_cyc({tag, ".d"}, S_D, SB_NONE, A_ADD);
    step(0, ins, 1, 0); exp_cyc({tag, ".e"}, S_E, SB_IMM, A_ADD);
    for (int i = 0; i < waits; i++) begin
      step(0, ins, 0, 0); exp_cyc({tag, ".mwait"}, S_M, sb_mem, A_ADD);
    end
    if (completes) begin
      step(0, ins, 1, 0); exp_cyc({tag, ".mdone"}, S_M, sb_mem, A_ADD);
      if (!st) begin
        step(0, ins, 1, 0); exp_cyc({tag, ".w"}, S_W, SB_WB_LD, A_ADD);
      end
    end else begin
      step(0, ins, 0, 0); exp_cyc({tag, ".trap"}, S_T, SB_NONE, A_ADD);
      check_trap({tag, ".trap"}, 1'b1, 2'b10);
    end
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; mem_ready = 1'b0; zero = 1'b0;
    step(1, 32'h00000013, 0, 0);
    step(1, 32'h00000013, 0, 0);

    // First cycle after reset: a fresh fetch request
    step(0, I_ADD, 0, 0);
    exp_cyc("reset", S_F, SB_FWAIT, A_ADD);
    check_trap("reset", 1'b0, 2'b00);

    // R-type and I-type arithmetic
    run_alu("add",    I_ADD,        A_ADD,     1'b0);
    run_alu("sub",    32'h402081B3, A_SUB,     1'b0);
    run_alu("and",    32'h0020F1B3, A_AND,     1'b0);
    run_alu("or",     32'h0020E1B3, A_OR,      1'b0);
    run_alu("slt",    32'h0020A1B3, A_SLT,     1'b0);
    run_alu("xor",    32'h0020C1B3, A_XOR_EXP, 1'b0);
    run_alu("addi",   32'h00108193, A_ADD,     1'b1);
    run_alu("addihi", 32'h40008193, A_ADD,     1'b1);
    run_alu("slti",   32'h0010A193, A_SLT,     1'b1);
    run_alu("andi",   32'h0010F193, A_AND,     1'b1);

    // Loads and stores
    run_mem("lw", I_LW,         1'b0, 3, 1'b1);
    run_mem("sw", 32'h0020A023, 1'b1, 0, 1'b1);

    // Branches
    run_branch("beq_t",  32'h00208063, 1'b1, 1'b1);
    run_branch("beq_nt", 32'h00208063, 1'b0, 1'b0);
    run_branch("bne_t",  32'h00209063, 1'b0, 1'b1);
    run_branch("bne_nt", 32'h00209063, 1'b1, 1'b0);
    run_branch("blt",    32'h0020C063, 1'b1, 1'b0);

    // Illegal opcode traps after DECODE; only reset leaves TRAP
    step(0, I_ILL, 1, 0); exp_cyc("ill.f", S_F, SB_FDONE, A_ADD);
    step(0, I_ILL, 1, 0); exp_cyc("ill.d", S_D, SB_NONE, A_ADD);
    step(0, I_ILL, 1, 0); exp_cyc("ill.t", S_T, SB_NONE, A_ADD);
    check_trap("ill.t", 1'b1, 2'b01);
    step(0, I_ILL, 1, 0); exp_cyc("ill.hold", S_T, SB_NONE, A_ADD);
    step(1, I_ILL, 1, 0); exp_cyc("ill.rst", S_T, SB_NONE, A_ADD);

    // Fetch wait interrupted by reset: counter must restart from zero
    for (int i = 0; i < 3; i++) begin
      step(0, I_ADD, 0, 0); exp_cyc("tof.pre", S_F, SB_FWAIT, A_ADD);
    end
    check_trap("ill.cleared", 1'b0, 2'b00);
    step(1, I_ADD, 0, 0); exp_cyc("tof.rst", S_F, SB_FWAIT, A_ADD);
    for (int i = 0; i < 5; i++) begin
      step(0, I_ADD, 0, 0); exp_cyc("tof.wait", S_F, SB_FWAIT, A_ADD);
    end
    step(0, I_ADD, 0, 0); exp_cyc("tof.trap", S_T, SB_NONE, A_ADD);
    check_trap("tof.trap", 1'b1, 2'b10);
    step(1, I_ADD, 1, 0); exp_cyc("tof.rst2", S_T, SB_NONE, A_ADD);

    // Completion on the fifth wait cycle wins over the timeout
    for (int i = 0; i < 4; i++) begin
      step(0, I_ADD, 0, 0); exp_cyc("late.wait", S_F, SB_FWAIT, A_ADD);
    end
    check_trap("late.clr", 1'b0, 2'b00);
    step(0, I_ADD, 1, 0); exp_cyc("late.done", S_F, SB_FDONE, A_ADD);
    step(0, I_ADD, 1, 0); exp_cyc("late.d", S_D, SB_NONE, A_ADD);
    step(0, I_ADD, 1, 0); exp_cyc("late.e", S_E, SB_NONE, A_ADD);
    step(0, I_ADD, 1, 0); exp_cyc("late.w", S_W, SB_WB, A_ADD);

    // Memory-phase timeout
    run_mem("lw_to", I_LW, 1'b0, 5, 1'b0);
    step(1, I_ADD, 0, 0); exp_cyc("lw_to.rst", S_T, SB_NONE, A_ADD);
    step(0, I_ADD, 0, 0); exp_cyc("final", S_F, SB_FWAIT, A_ADD);
    check_trap("final", 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter TIMEOUT_W, default 8, setting the width of the memory-wait timeout counter.
REQ-002 The block SHALL have parameter TIMEOUT_MAX, default 255, giving the wait cycles before a timeout trap; it SHALL be at most 2^TIMEOUT_W-1.
REQ-003 One clock and one reset: clk  input  1  rising-edge clock; rst  input  1  synchronous, active-high reset.
REQ-004 instr  input  32  current instruction-register contents (opcode [6:0], funct3 [14:12], funct7 [31:25]).
REQ-005 mem_ready  input  1  memory completion for the current request; zero  input  1  ALU zero flag.
REQ-006 mem_req  output  1  memory request; mem_we  output  1  write strobe; iord  output  1  0 = PC address, 1 = ALU address.
REQ-007 ir_write, pc_write, pc_src (0 = PC+4, 1 = branch target), reg_write, mem_to_reg, alu_src  outputs  1 each.
REQ-008 alu_ctl  output  4  ALU operation; state  output  3  current FSM state; trap  output  1  trap flag; trap_cause  output  2  trap reason.

Function
REQ-009 The FSM SHALL have six states: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4 and TRAP=5; state SHALL be registered and change only on clk.
REQ-010 All outputs other than state, trap and trap_cause SHALL be combinational from state, instr, mem_ready and zero; unlisted outputs SHALL default to 0, with alu_ctl defaulting to ADD.
REQ-011 ALU codes SHALL be: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111; extended codes are XOR=0011, SLL=0100, SRL=0101, SRA=1000, SLTU=1001.
REQ-012 FETCH SHALL hold mem_req=1 with iord=0 until mem_ready=1; in that cycle it SHALL assert ir_write=1 and pc_write=1 with pc_src=0, then move to DECODE.
REQ-013 DECODE SHALL move to EXECUTE for opcodes 0110011, 0010011, 0000011, 0100011 and 1100011; any other opcode SHALL move to TRAP with trap_cause=01.
REQ-014 EXECUTE, R-type (0110011): funct3 000 SHALL give SUB when funct7=0100000 and ADD otherwise; 111 SHALL give AND, 110 OR, 010 SLT; next state WRITEBACK.
REQ-015 EXECUTE, I-type (0010011): alu_src=1; funct3 000 SHALL give ADD, 111 AND, 110 OR, 010 SLT; next state WRITEBACK.
REQ-016 EXECUTE, load or store: alu_src=1 and alu_ctl=ADD; next state MEM.
REQ-017 EXECUTE, branch: alu_ctl=SUB; pc_write=1 and pc_src=1 SHALL assert when (funct3=000 and zero=1) or (funct3=001 and zero=0); next state FETCH.
REQ-018 MEM SHALL hold mem_req=1 with iord=1 (mem_we=1 for a store) until mem_ready=1; a load then moves to WRITEBACK and a store to FETCH.
REQ-019 WRITEBACK SHALL pulse reg_write=1 for one cycle, with mem_to_reg=1 for a load and 0 otherwise; next state FETCH.
REQ-020 The wait counter SHALL increment each cycle mem_req=1 and mem_ready=0, and clear on mem_ready=1 or on any state change.
REQ-021 If the wait counter equals TIMEOUT_MAX and mem_ready=0, the next state SHALL be TRAP with trap_cause=10; if mem_ready=1 in the same cycle, completion SHALL win.
REQ-022 TRAP SHALL drive every strobe to 0, hold trap=1, and leave only on rst.
REQ-023 A memory request SHALL never be withdrawn: mem_req stays at 1 until mem_ready or a timeout.

Reset
REQ-024 When rst=1 at a clk edge: state=FETCH, wait counter=0, trap=0 and trap_cause=00.
REQ-025 Reset SHALL take priority over every transition, including in-flight memory waits and TRAP.
REQ-026 In the first cycle after reset, mem_req SHALL be 1 (a new fetch).

Configuration
REQ-027 Macro MC_EXT_ALU_EN, when defined, SHALL decode the R/I funct3 values 100 to XOR and 011 to SLTU, 001 to SLL, and 101 to SRL, or to SRA when funct7=0100000.
REQ-028 Without MC_EXT_ALU_EN, those funct3 values SHALL decode to ADD, and codes 0011, 0100, 0101, 1000 and 1001 SHALL never appear.

Structure
REQ-029 A shared package SHALL hold the opcode constants, ALU-code constants, the state enum and the trap-cause enum.
REQ-030 Opcode/funct decode SHALL live in one sub-module, mc_alu_decode, which is combinational; the FSM and counter SHALL live in the top module.

Verification
REQ-031 add x3,x1,x2 (0x002081B3), mem_ready=1 every cycle -> states 0,1,2,4,0; alu_ctl=0010 in EXECUTE; reg_write=1 for exactly one cycle.
REQ-032 lw (0x0000A183) with mem_ready delayed 3 cycles in MEM -> mem_req=1 and iord=1 for 4 cycles; then WRITEBACK with mem_to_reg=1.
REQ-033 beq with zero=1 -> pc_write=1 and pc_src=1 in EXECUTE; repeat with zero=0 -> pc_write=0.
REQ-034 Opcode 0x7F -> TRAP after DECODE with trap_cause=01; rst=1 for one cycle -> state=0 and trap=0.
REQ-035 TIMEOUT_MAX=4 with mem_ready held at 0 in FETCH -> TRAP with trap_cause=10; repeat with mem_ready=1 on the 5th wait cycle -> DECODE.
REQ-036 xor (funct3=100) -> alu_ctl=0011 with MC_EXT_ALU_EN defined and 0010 without it.
